// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: state encoding, difficulty codes
// and the difficulty-to-round-length mapping.
package game_pkg;

  typedef enum logic [1:0] {
    MENU      = 2'b00,
    COUNTDOWN = 2'b01,
    GAME      = 2'b10,
    SCORE     = 2'b11
  } game_state_e;

  localparam logic [1:0] LVL_EASY   = 2'd0;
  localparam logic [1:0] LVL_NORMAL = 2'd1;
  localparam logic [1:0] LVL_HARD   = 2'd2;

  localparam logic [9:0] SCORE_MAX = 10'd1023;

  // Levels 2 and 3 both play the hard round length.
  function automatic logic [7:0] levelTime(input logic [1:0] lvl,
                                           input logic [7:0] tEasy,
                                           input logic [7:0] tNormal,
                                           input logic [7:0] tHard);
    case (lvl)
      LVL_EASY:   return tEasy;
      LVL_NORMAL: return tNormal;
      default:    return tHard;
    endcase
  endfunction

endpackage

// File: rtl/game_ctrl_sec_tick.sv
// One-second tick generator: a one-cycle pulse after every CLK_HZ enabled
// cycles, restartable from zero with clr.
module sec_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] count_q, count_d;

  // tick must not depend on clr: clr is derived from the next state, which uses tick.
  assign tick = en & (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (count_q == LAST) count_d = '0;
      else                 count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/game_ctrl.sv
// Top-level game sequencer: MENU -> COUNTDOWN -> GAME -> SCORE -> MENU, with
// round-length selection, countdown, saturating score and high-score tracking.
module game_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int COUNTDOWN_S  = 3,
  parameter int SCORE_HOLD_S = 5,
  parameter int TIME_EASY    = 60,
  parameter int TIME_NORMAL  = 45,
  parameter int TIME_HARD    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic [1:0] level_sel,
  input  logic       end_of_time,
  input  logic       hit,
  output logic [1:0] state_out,
  output logic [7:0] time_out,
  output logic [1:0] countdown,
  output logic [9:0] score,
  output logic [9:0] high_score,
  output logic       new_record
);

  localparam int HW = (SCORE_HOLD_S > 1) ? $clog2(SCORE_HOLD_S + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(SCORE_HOLD_S - 1);
  localparam logic [1:0]    CD_INIT   = 2'(COUNTDOWN_S);

  game_state_e   state_q, state_d;
  logic          startPrev_q;
  logic [7:0]    roundTime_q, roundTime_d;
  logic [1:0]    countdown_q, countdown_d;
  logic [9:0]    score_q, score_d;
  logic [9:0]    highScore_q, highScore_d;
  logic          newRecord_q, newRecord_d;
  logic [HW-1:0] holdCnt_q, holdCnt_d;

  logic startRise;
  logic secTick;
  logic tickClr;
  logic tickEn;

  assign startRise = start_btn & ~startPrev_q;
  assign tickEn    = (state_q == COUNTDOWN) || (state_q == SCORE);
  assign tickClr   = (state_d != state_q);

  sec_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tickClr),
    .en   (tickEn),
    .tick (secTick)
  );

  // Next-state and datapath updates; the high-score compare sees the score
  // including a hit that coincides with end_of_time.
  always_comb begin
    state_d     = state_q;
    roundTime_d = roundTime_q;
    countdown_d = countdown_q;
    score_d     = score_q;
    highScore_d = highScore_q;
    newRecord_d = newRecord_q;
    holdCnt_d   = holdCnt_q;

    case (state_q)
      MENU: begin
        if (startRise) begin
          roundTime_d = levelTime(level_sel, 8'(TIME_EASY), 8'(TIME_NORMAL), 8'(TIME_HARD));
          score_d     = '0;
          newRecord_d = 1'b0;
          countdown_d = CD_INIT;
          state_d     = COUNTDOWN;
        end
      end
      COUNTDOWN: begin
        if (secTick) begin
          if (countdown_q == 2'd1) begin
            countdown_d = 2'd0;
            state_d     = GAME;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end
      end
      GAME: begin
        if (hit && (score_q != SCORE_MAX)) score_d = score_q + 10'd1;
        if (end_of_time) begin
          state_d   = SCORE;
          holdCnt_d = '0;
          if (score_d > highScore_q) begin
            highScore_d = score_d;
            newRecord_d = 1'b1;
          end
        end
      end
      SCORE: begin
        if (startRise) begin
          state_d = MENU;
        end else if (secTick) begin
          if (holdCnt_q == HOLD_LAST) state_d = MENU;
          else                        holdCnt_d = holdCnt_q + HW'(1);
        end
      end
    endcase
  end

  // The edge register resets high so a button held through reset is not a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MENU;
      startPrev_q <= 1'b1;
      roundTime_q <= 8'(TIME_EASY);
      countdown_q <= '0;
      score_q     <= '0;
      highScore_q <= '0;
      newRecord_q <= 1'b0;
      holdCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      startPrev_q <= start_btn;
      roundTime_q <= roundTime_d;
      countdown_q <= countdown_d;
      score_q     <= score_d;
      highScore_q <= highScore_d;
      newRecord_q <= newRecord_d;
      holdCnt_q   <= holdCnt_d;
    end
  end

  assign state_out  = state_q;
  assign time_out   = roundTime_q;
  assign countdown  = countdown_q;
  assign score      = score_q;
  assign high_score = highScore_q;
  assign new_record = newRecord_q;

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer. Owns the 2-bit game state consumed by `game_timer` and the rest of the design, and supplies the round duration on `time_out`. Sequences MENU → COUNTDOWN → GAME → SCORE → MENU, and accumulates score and high score. Exit from GAME is driven solely by the timer's `end_of_time`.

## Interface

Parameters:
- `CLK_HZ`, 100_000_000: clock cycles per second (100 MHz, T = 10 ns).
- `COUNTDOWN_S`, 3: pre-game countdown length in seconds (1..3).
- `SCORE_HOLD_S`, 5: seconds the SCORE screen is held before auto-return to MENU.
- `TIME_EASY`, 60: round length in seconds for level 0.
- `TIME_NORMAL`, 45: round length in seconds for level 1.
- `TIME_HARD`, 30: round length in seconds for levels 2 and 3.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `start_btn`, in, 1: start button level, already synchronised and debounced.
- `level_sel`, in, 2: difficulty select. Sampled only on a start edge in MENU.
- `end_of_time`, in, 1: one-cycle pulse from `game_timer` when the round time has elapsed.
- `hit`, in, 1: one-cycle pulse per point scored.
- `state_out`, out, 2: game state. MENU=00, COUNTDOWN=01, GAME=10, SCORE=11.
- `time_out`, out, 8: round length in seconds, to `game_timer` `time_in`.
- `countdown`, out, 2: seconds remaining in COUNTDOWN. 0 in all other states.
- `score`, out, 10: current round score, saturating at 1023.
- `high_score`, out, 10: best score since reset.
- `new_record`, out, 1: high when the last completed round set a new high score.

## Operation

- Start edge: `start_rise = start_btn & ~start_btn_d`.
  - `start_btn_d` resets to 1, so a button held through reset does not start a game.
- MENU
  - On `start_rise`: latch the level into `time_out` (EASY/NORMAL/HARD mapping).
  - Clear `score` and `new_record`.
  - Load `countdown = COUNTDOWN_S`, clear the tick counter, go to COUNTDOWN.
- COUNTDOWN
  - On each 1 s tick, decrement `countdown`.
  - On the tick where `countdown == 1`, set `countdown` to 0 and go to GAME.
- GAME
  - On `hit`, `score = min(score+1, 1023)`.
  - On `end_of_time`, go to SCORE.
  - `start_rise` is ignored in GAME.
- SCORE
  - On entry, if the final score > `high_score`, set `high_score` to the final score and set `new_record`.
  - A tie is not a record.
  - Return to MENU after `SCORE_HOLD_S` ticks, or earlier on `start_rise`.
  - Returning to MENU does not start a new game; a second edge is required.
- `time_out` holds its latched value in every state. `game_timer` requires a stable `time_in` throughout GAME.
- `hit` outside GAME is ignored.
- `end_of_time` outside GAME is ignored.

## Timing

- All outputs are registered.
- Reset values:
  - `state_out` = MENU.
  - `time_out` = `TIME_EASY`.
  - `countdown`, `score`, `high_score`, `new_record` = 0.
- Latency: every state change appears on `state_out` one cycle after the triggering input or tick.
- Tick counter:
  - Width `$clog2(CLK_HZ)`.
  - Counts 0..CLK_HZ-1 only in COUNTDOWN and SCORE.
  - The tick pulse fires when the count is CLK_HZ-1; the counter then wraps to 0.
  - The counter clears on every state entry, so the first tick arrives exactly CLK_HZ cycles after entry.
- `hit` and `end_of_time` in the same cycle: the hit is counted, and the high-score compare uses the incremented score.
- `start_rise` and the hold-timeout tick in the same cycle in SCORE: go to MENU once; no game starts.
- Reset asserted mid-operation returns everything, including `high_score`, to reset values immediately and asynchronously.

## Structure

- Shared package `game_pkg`:
  - State localparams `MENU`, `COUNTDOWN`, `GAME`, `SCORE`. `game_timer` uses the same `GAME` encoding.
  - Level codes `LVL_EASY`, `LVL_NORMAL`, `LVL_HARD`.
- Sub-module `sec_tick`:
  - Parameter `CLK_HZ`; inputs `clk`, `rst`, `clr`, `en`; output `tick`.
  - Produces a one-cycle pulse every CLK_HZ enabled cycles.
- `game_ctrl` contains:
  - the state machine,
  - the start-edge register,
  - the level-to-time mapping,
  - the countdown, score and high-score registers.

## Test plan

All scenarios use `CLK_HZ=10`, `COUNTDOWN_S=3`, `SCORE_HOLD_S=5`.

1. **Reset with button held.** Reset released with `start_btn=1` held → `state_out` stays 00. Release then press → COUNTDOWN one cycle after the edge, `countdown=3`.
2. **Level latch and countdown.** `level_sel=2` at the start edge → `time_out=30`. `countdown` goes 3→2→1 at 10-cycle intervals. `state_out`=10 exactly 30 cycles after COUNTDOWN entry. Changing `level_sel` afterwards leaves `time_out` at 30.
3. **Scoring, saturation, coincident end.**
   - 5 `hit` pulses in GAME → `score=5`; hits in MENU are ignored.
   - 1030 hits → `score=1023`.
   - `hit` coincident with `end_of_time` → counted; state becomes 11.
4. **High-score rules.**
   - Round scores 7 then 7 → `high_score=7`; `new_record`=1 after round 1, 0 after round 2.
   - Round score 9 → `high_score=9`, `new_record=1`.
5. **SCORE exit.**
   - No button → MENU 50 cycles after SCORE entry.
   - `start_rise` at cycle 12 → MENU on the next cycle, with no automatic COUNTDOWN.
6. **Async reset mid-round.** `rst` pulse mid-GAME, between clock edges → all outputs reach reset values before the next edge, including `high_score=0`.
